// File: rtl/serial_frame_pkg.sv
// Shared definitions for the single-wire serial frame link (tx now, rx later):
// state encoding, idle line level and the parity helper.
package serial_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic IDLE_LEVEL = 1'b1;

  // Widest word the parity helper covers; callers zero-extend into it.
  localparam int PAR_MAX_W = 64;

  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first,
// optional parity, stop bit; each bit held CLKS_PER_BIT cycles.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_SEL    = (PARITY_ODD != 0);

  logic [2:0]           state;
  logic [DATA_W-1:0]    shreg;
  logic [DATA_W-1:0]    shifted;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 parity_bit;
  logic                 line_q;
  logic                 tick;
  logic                 accept;
  logic [PAR_MAX_W-1:0] data_ext;

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign tx_out   = line_q;
  assign accept   = tx_valid && tx_ready;
  assign shifted  = shreg >> 1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    data_ext                = '0;
    data_ext[DATA_W-1:0]    = tx_data;
  end

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .tick  (tick)
  );

  // The line level is registered together with the state it belongs to,
  // so tx_out changes on the same edge as the state transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      // NOTE: the shift register is cleared on reset so a stale word never leaks.
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      line_q     <= IDLE_LEVEL;
    end else begin
      case (state)
        ST_IDLE: begin
          line_q <= IDLE_LEVEL;
          if (tx_valid) begin
            shreg      <= tx_data;
            parity_bit <= calc_parity(data_ext, ODD_SEL);
            state      <= ST_START;
            line_q     <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            line_q  <= shreg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state  <= HAS_PARITY ? ST_PARITY : ST_STOP;
              line_q <= HAS_PARITY ? parity_bit : IDLE_LEVEL;
            end else begin
              line_q <= shifted[0];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state  <= ST_STOP;
            line_q <= IDLE_LEVEL;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state  <= ST_IDLE;
            line_q <= IDLE_LEVEL;
          end
        end
        default: begin
          state  <= ST_IDLE;
          line_q <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: four parameterisations share one clock
// and reset; expected frames are hand-computed transmission-order bit vectors.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_v [4];
  logic [7:0] data_v  [4];
  logic       ready_v [4];
  logic       out_v   [4];
  logic       busy_v  [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_plain (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_out(out_v[0]), .busy(busy_v[0]));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_out(out_v[1]), .busy(busy_v[1]));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx_out(out_v[2]), .busy(busy_v[2]));

  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(data_v[3][3:0]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx_out(out_v[3]), .busy(busy_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present a word at a negedge; the following posedge is the accept edge.
  task automatic send(input int idx, input logic [7:0] d, input bit keep_valid);
    @(negedge clk);
    valid_v[idx] = 1'b1;
    data_v[idx]  = d;
    @(posedge clk);
    #1;
    if (!keep_valid) valid_v[idx] = 1'b0;
  endtask

  // Called right after the accept edge; bit i of bits is the i-th bit on the wire.
  task automatic frame(input int idx, input logic [15:0] bits, input int nbits,
                       input int cpb, input string tag);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        check({tag, "_line"}, 32'(out_v[idx]), 32'(bits[b]));
        check({tag, "_busy"}, 32'(busy_v[idx]), 32'd1);
      end
    end
    @(negedge clk);
    check({tag, "_idle_busy"},  32'(busy_v[idx]),  32'd0);
    check({tag, "_idle_ready"}, 32'(ready_v[idx]), 32'd1);
    check({tag, "_idle_line"},  32'(out_v[idx]),   32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_v[i] = 1'b1;
      data_v[i]  = 8'hA5;
    end

    // Reset held 3 cycles with valid high: nothing may start.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check("rst_line",  32'(out_v[i]),   32'd1);
        check("rst_ready", 32'(ready_v[i]), 32'd1);
        check("rst_busy",  32'(busy_v[i]),  32'd0);
      end
    end

    // Release reset with valid still high on the plain DUT: accept on that edge.
    for (int i = 1; i < 4; i++) valid_v[i] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    frame(0, 16'h034A, 10, 4, "a5_plain");

    // Valid held high; data switched to 0xFF mid-frame.
    send(0, 8'hA5, 1'b1);
    fork
      frame(0, 16'h034A, 10, 4, "hs_first");
      begin
        repeat (10) @(negedge clk);
        data_v[0] = 8'hFF;
      end
    join
    // The very next edge must accept 0xFF.
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    frame(0, 16'h03FE, 10, 4, "hs_second");

    send(1, 8'hA5, 1'b0);
    frame(1, 16'h054A, 11, 4, "a5_even");
    send(2, 8'hA5, 1'b0);
    frame(2, 16'h074A, 11, 4, "a5_odd");
    send(1, 8'h07, 1'b0);
    frame(1, 16'h060E, 11, 4, "07_even");

    send(3, 8'h09, 1'b0);
    frame(3, 16'h0032, 6, 1, "fast_9");

    // Reset during data bit 3 (cycles 17..20 after accept).
    send(0, 8'hA5, 1'b0);
    repeat (18) @(negedge clk);
    check("mid_busy_before", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_line",  32'(out_v[0]),   32'd1);
    check("mid_rst_busy",  32'(busy_v[0]),  32'd0);
    check("mid_rst_ready", 32'(ready_v[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h3C, 1'b0);
    frame(0, 16'h0278, 10, 4, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Synchronous serial frame transmitter that accepts a parallel word over a valid/ready handshake and shifts it out on a single wire, one bit per bit period. Frames are start bit, data bits LSB first, optional parity, stop bit. It sits upstream of the D flip-flop sampling stage and drives the serial `D` stream that the flip-flop captures on `clk` rising edges. It is the transmit end of that single-wire link.

## Interface
- `DATA_W`, 8: data bits per frame, ≥1.
- `CLKS_PER_BIT`, 4: clock cycles each serial bit is held, ≥1.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN`=1, 0 selects even parity and 1 selects odd parity.
- `clk`, input, 1: rising-edge clock, single domain.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `tx_data`, input, `DATA_W`: word to send. Sampled only on accept.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: block can accept a word.
- `tx_out`, output, 1: serial line. Idle level is 1.
- `busy`, output, 1: a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - Encoding uses localparams. Illegal states return to IDLE.
- Accept occurs on a rising edge where `tx_valid`=1 and `tx_ready`=1.
  - `tx_data` is latched into a shift register.
  - Parity is computed from the latched word.
  - State moves IDLE→START.
- `tx_ready` = (state==IDLE).
- `busy` = (state!=IDLE).
- While `busy`=1, `tx_valid` and `tx_data` are ignored. Changes to `tx_data` after accept do not affect the frame.
- Line value per state:
  - START: 0.
  - DATA: shift register bit 0; shift right once per completed bit period.
  - PARITY: XOR of the latched data bits, XOR `PARITY_ODD`.
  - STOP: 1.
  - IDLE: 1.
- Transitions happen when the bit timer expires:
  - START→DATA.
  - DATA→DATA until `DATA_W` bits have been sent, then DATA→PARITY if `PARITY_EN`=1, else DATA→STOP.
  - PARITY→STOP.
  - STOP→IDLE.
- Bit timer: counts 0..`CLKS_PER_BIT`-1, width `$clog2(CLKS_PER_BIT)` with a minimum of 1. It expires at `CLKS_PER_BIT`-1, wraps to 0, and is cleared on accept.
- Bit counter: width `$clog2(DATA_W+1)`. It is cleared on entering DATA and counts the bits sent.
- Reset: synchronous with `rst_n`=0, and takes priority over everything, including mid-frame. After the reset edge:
  - state=IDLE, `tx_out`=1, `tx_ready`=1, `busy`=0.
  - Counters are 0. The shift register is 0.
  - Any partial frame is abandoned; no stop bit is completed.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Accept at edge N: `tx_out`=0 from edge N (visible in cycle N+1) for `CLKS_PER_BIT` cycles.
- Frame length is F = `CLKS_PER_BIT`×(2+`DATA_W`+`PARITY_EN`) cycles. `busy`=1 for exactly F cycles.
- After STOP, the block spends a minimum of 1 cycle in IDLE (`tx_ready`=1) before the next accept. Back-to-back frames are therefore spaced F+1 cycles apart.
- `CLKS_PER_BIT`=1: every bit lasts 1 cycle, and the timer expires every cycle.
- `tx_valid` may be asserted in the same cycle reset is released. Accept requires `rst_n`=1 on that edge.

## Structure
- Shared package `serial_frame_pkg` holds:
  - state encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - the idle line level;
  - a parity helper function.
  A future `serial_frame_rx` reuses this package.
- One sub-module, `bit_timer`: parameter `CLKS_PER_BIT`; inputs `clk`, `rst_n`, `clear`; output a `tick` pulse on expiry.
- Top-level logic: FSM, shift register, bit counter, output decode.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `tx_valid`=1 → `tx_out`=1, `tx_ready`=1, `busy`=0, and no frame starts.
- Basic frame, `DATA_W`=8, `CLKS_PER_BIT`=4, no parity: send 0xA5 → `tx_out` is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `busy` is high for 40 cycles, then `tx_ready`=1.
- Parity with 0xA5:
  - even → parity bit 0, frame is 44 cycles;
  - odd → parity bit 1.
  - Send 0x07 with even parity → parity bit 1.
- Handshake:
  - hold `tx_valid`=1 and change `tx_data` to 0xFF mid-frame → the current frame is still 0xA5;
  - the second frame starts exactly 1 idle cycle after stop ends, and carries 0xFF.
- Reset mid-frame: drop `rst_n` during data bit 3 → on the next edge `tx_out`=1 and `busy`=0; a new accept afterwards sends a full, correct frame.
- `CLKS_PER_BIT`=1, `DATA_W`=4: send 0x9 → `tx_out` is 0,1,0,0,1,1 on consecutive cycles.
